apb_gpio: RTL and testbench
===========================

Name: apb_gpio

Overview:
- APB (AMBA 2, no PREADY/PSLVERR) slave exposing a 32-bit general-purpose I/O port. It is the responder to the GPIO APB tester/initiator.
- Six 32-bit CSRs in a 32-byte window: CONTROL, LINE, MASK, IRQ, EDGE and POL.
- Per-pin direction control, output drive and input sampling.
- Per-pin interrupt detection: level or edge, selectable polarity, maskable, with sticky status.
- A single interrupt line goes to the system interrupt controller.

Parameters:
- SYNC_STAGES, 2: number of flip-flops in the GPIO_I synchronizer. Legal values are 2 or more.

Ports:
- PCLK  input  1  APB clock; all logic is on its rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PADDR  input  32  byte address. Only PADDR[4:2] is decoded.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- GPIO_I  input  32  pad input values (asynchronous).
- GPIO_O  output  32  pad output values; equals the LINE output register.
- GPIO_T  output  32  pad output enable; 1 = drive, equals CONTROL.
- IRQ  output  1  active-high interrupt.

Behaviour:
- Register map (offset, reset value, access):
  - CONTROL 0x00, reset 0, RW. Bit = 1 makes the pin an output.
  - LINE 0x04, RW.
    - Write loads the output register (reset 0).
    - Read returns the synchronized GPIO_I for all 32 bits.
  - MASK 0x08, reset 0xFFFF_FFFF, RW. Bit = 1 masks that pin's interrupt.
  - IRQ 0x0C, reset 0, read / write-0-to-clear.
  - EDGE 0x10, reset 0, RW. 0 = level, 1 = edge.
  - POL 0x14, reset 0, RW.
    - 0 = active-low level or falling edge.
    - 1 = active-high level or rising edge.
  - 0x18 and 0x1C: read 0, writes ignored.
- Write strobe is PSEL & PENABLE & PWRITE. The register updates on that rising edge of PCLK; there is no wait state.
- Read strobe is PSEL & ~PENABLE & ~PWRITE (setup phase).
  - PRDATA is registered on that edge, so it is valid throughout the access phase.
  - In every other cycle PRDATA is loaded with 0.
- Input path:
  - GPIO_I passes through a SYNC_STAGES flop chain to give sync_in.
  - One further register, prev_in, holds the previous sync_in.
  - LINE read returns sync_in.
- Per-bit event, evaluated every cycle:
  - Level mode (EDGE = 0): event = (sync_in == POL).
  - Edge mode (EDGE = 1) with POL = 1: event = sync_in & ~prev_in.
  - Edge mode (EDGE = 1) with POL = 0: event = ~sync_in & prev_in.
- IRQ status update each cycle: status_next = (status & clear_keep) | (event & ~MASK).
  - clear_keep = PWDATA during an IRQ-register write strobe, else all-ones.
  - A set in the same cycle as a clear wins: a persisting level event re-asserts the bit the next cycle.
- Masking:
  - Setting a MASK bit blocks new sets only. It does not clear existing status.
  - Software clears status by writing 0 after masking.
- IRQ output:
  - IRQ = |status, registered, so it lags status by one cycle.
  - IRQ is 0 in reset.
- Changing EDGE or POL does not clear status. It may create a spurious level event, which is software's responsibility.
- Reset (asynchronous, any time, including mid-transfer):
  - All registers, sync flops and prev_in go to their reset values.
  - PRDATA = 0, IRQ = 0, GPIO_O = 0, GPIO_T = 0.
  - Any in-flight transfer is dropped.
- Latency:
  - A pin change reaches sync_in after SYNC_STAGES cycles.
  - status follows one cycle after that; IRQ follows one further cycle.

Test Plan:
- Reset read-back (GPIO_I pulled high):
  - Read all CSRs -> CONTROL = 0, LINE = 0xFFFF_FFFF, MASK = 0xFFFF_FFFF, IRQ = 0, EDGE = 0, POL = 0, IRQ pin low.
- Direction, with the bench wiring GPIO_I = GPIO_T ? GPIO_O : pull-up:
  - Write LINE = 0xAAAA_5555, then CONTROL = 0xFFFF_0000.
  - LINE reads 0xAAAA_FFFF; IRQ reads 0.
- Active-low level:
  - Write LINE = 0xAAAA_5555, CONTROL = 0x0000_FFFF, then MASK = 0.
  - IRQ reads 0x0000_AAAA and the IRQ pin is high.
  - Write MASK = 0xFFFF_FFFF, then IRQ = 0 -> IRQ reads 0 and the pin drops.
- Rising edge:
  - Setup: CONTROL = all ones, LINE = 0, EDGE = all ones, POL = all ones, MASK = 0.
  - Write LINE = 0x1234_5678 -> IRQ reads 0x1234_5678.
  - Mask and clear -> IRQ reads 0.
  - Unmask and write LINE = 0xEDCB_A987 -> IRQ reads 0xEDCB_A987.
- Falling edge:
  - Setup: LINE = all ones, EDGE = all ones, POL = 0, MASK = 0.
  - Write LINE = 0x1234_5678 -> IRQ reads 0xEDCB_A987.
  - Write LINE = 0xEDCB_A987 -> IRQ reads 0x1234_5678.
- Corner cases:
  - An IRQ write of 0 coinciding with an unmasked active level leaves the bit set.
  - Offsets 0x18 and 0x1C read 0.
  - PRESETn asserted mid-access-phase forces PRDATA = 0 and IRQ = 0 immediately.

Source files
------------

// File: rtl/apb_gpio_if.sv
// APB (AMBA 2) bus bundle for the GPIO slave.
// There is no PREADY or PSLVERR, so every access completes in two cycles.
interface apb_gpio_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/apb_gpio.sv
// APB GPIO slave: 32 pins with direction, output drive and synchronized input.
// Each pin also has a maskable level/edge interrupt with sticky status.
module apb_gpio_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic pin,
    input  logic edge_mode,
    input  logic pol,
    input  logic mask,
    input  logic keep,
    output logic sync_in,
    output logic status
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_in;
    logic                   evt;

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_comb begin
        if (edge_mode) evt = pol ? (sync_in & ~prev_in) : (~sync_in & prev_in);
        else           evt = (sync_in == pol);
    end

    // The set term is ORed in after the clear, so a persisting event beats a write-0.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q  <= '0;
            prev_in <= 1'b0;
            status  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_in <= sync_in;
            status  <= (status & keep) | (evt & ~mask);
        end
    end
endmodule

module apb_gpio #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    apb_gpio_if.slave   apb,
    input  logic [31:0] GPIO_I,
    output logic [31:0] GPIO_O,
    output logic [31:0] GPIO_T,
    output logic        IRQ
);
    localparam int NUM_LANES = 32;

    logic [NUM_LANES-1:0] ctl_q, line_q, mask_q, edge_q, pol_q;
    logic [NUM_LANES-1:0] sync_in, status, keep;
    logic [31:0]          rdata;
    logic [2:0]           idx;
    logic                 wr, rd;
    logic                 unused_addr;

    assign idx         = apb.PADDR[4:2];
    assign wr          = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd          = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    assign unused_addr = ^{apb.PADDR[31:5], apb.PADDR[1:0]};
    assign keep        = (wr && idx == 3'd3) ? apb.PWDATA : '1;
    assign GPIO_O      = line_q;
    assign GPIO_T      = ctl_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        apb_gpio_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .PCLK     (PCLK),
            .PRESETn  (PRESETn),
            .pin      (GPIO_I[i]),
            .edge_mode(edge_q[i]),
            .pol      (pol_q[i]),
            .mask     (mask_q[i]),
            .keep     (keep[i]),
            .sync_in  (sync_in[i]),
            .status   (status[i])
        );
    end

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0:    rdata = ctl_q;
            3'd1:    rdata = sync_in;
            3'd2:    rdata = mask_q;
            3'd3:    rdata = status;
            3'd4:    rdata = edge_q;
            3'd5:    rdata = pol_q;
            default: rdata = '0;
        endcase
    end

    // The IRQ status register has no storage of its own here: writes reach the lanes through keep.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctl_q      <= '0;
            line_q     <= '0;
            mask_q     <= '1;
            edge_q     <= '0;
            pol_q      <= '0;
            apb.PRDATA <= '0;
            IRQ        <= 1'b0;
        end else begin
            if (wr) begin
                case (idx)
                    3'd0:    ctl_q  <= apb.PWDATA;
                    3'd1:    line_q <= apb.PWDATA;
                    3'd2:    mask_q <= apb.PWDATA;
                    3'd4:    edge_q <= apb.PWDATA;
                    3'd5:    pol_q  <= apb.PWDATA;
                    default: ;
                endcase
            end
            apb.PRDATA <= rd ? rdata : '0;
            IRQ        <= |status;
        end
    end
endmodule

// File: tb/tb_apb_gpio.sv
// Bench for apb_gpio: a table of directed APB operations, hand-written corner cases, and a random phase.
// A word-level cycle model shadows every output throughout.
module tb_apb_gpio;
    localparam int SS = 2;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [31:0] GPIO_I, GPIO_O, GPIO_T, ext_in;
    logic        IRQ;
    int          n_cmp = 0, n_bad = 0;
    bit          chk_en = 0;

    apb_gpio_if bus ();

    apb_gpio #(.SYNC_STAGES(SS)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus.slave),
        .GPIO_I(GPIO_I), .GPIO_O(GPIO_O), .GPIO_T(GPIO_T), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;
    assign GPIO_I = (GPIO_T & GPIO_O) | (~GPIO_T & ext_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word-wide reference model: pins feed a queue SS deep, and the oldest entry is sync_in.
    logic [31:0] m_ctl, m_line, m_mask, m_edg, m_pol, m_stat, m_prev, m_prdata;
    logic        m_irq;
    logic [31:0] m_q[$];
    logic [31:0] m_pins, m_sync, m_evt, m_keep, m_rdv;
    logic [2:0]  m_idx;
    bit          m_wr, m_rd;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_ctl = 0; m_line = 0; m_mask = '1; m_edg = 0; m_pol = 0;
            m_stat = 0; m_prev = 0; m_prdata = 0; m_irq = 0;
            m_q.delete();
            for (int i = 0; i < SS; i++) m_q.push_back(32'h0);
        end else begin
            m_sync = m_q[0];
            m_pins = (m_ctl & m_line) | (~m_ctl & ext_in);
            m_evt  = (~m_edg & ~(m_sync ^ m_pol))
                   | (m_edg & m_pol & m_sync & ~m_prev)
                   | (m_edg & ~m_pol & ~m_sync & m_prev);
            m_idx  = bus.PADDR[4:2];
            m_wr   = bus.PSEL && bus.PENABLE && bus.PWRITE;
            m_rd   = bus.PSEL && !bus.PENABLE && !bus.PWRITE;
            m_keep = (m_wr && m_idx == 3) ? bus.PWDATA : '1;
            case (m_idx)
                0: m_rdv = m_ctl;  1: m_rdv = m_sync; 2: m_rdv = m_mask;
                3: m_rdv = m_stat; 4: m_rdv = m_edg;  5: m_rdv = m_pol;
                default: m_rdv = 0;
            endcase
            m_prdata = m_rd ? m_rdv : 0;
            m_irq    = |m_stat;
            m_stat   = (m_stat & m_keep) | (m_evt & ~m_mask);
            if (m_wr)
                case (m_idx)
                    0: m_ctl = bus.PWDATA;  1: m_line = bus.PWDATA; 2: m_mask = bus.PWDATA;
                    4: m_edg = bus.PWDATA;  5: m_pol = bus.PWDATA;
                    default: ;
                endcase
            m_prev = m_sync;
            void'(m_q.pop_front());
            m_q.push_back(m_pins);
        end
    end

    always @(negedge PCLK) begin
        if (chk_en && PRESETn) begin
            chk("model_prdata", bus.PRDATA, m_prdata);
            chk("model_irq", {31'd0, IRQ}, {31'd0, m_irq});
            chk("model_gpio_o", GPIO_O, m_line);
            chk("model_gpio_t", GPIO_T, m_ctl);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = addr; bus.PWDATA = data;
        @(negedge PCLK);
        bus.PENABLE = 1;
        @(negedge PCLK);
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge PCLK);
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = addr;
        @(negedge PCLK);
        data = bus.PRDATA;
        bus.PENABLE = 1;
        @(negedge PCLK);
        bus.PSEL = 0; bus.PENABLE = 0;
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;   // write data, or the expected read value
        bit          chk_pin;
        bit          pin;
    } op_t;

    op_t tbl[$];

    function automatic op_t mk(bit wr, logic [4:0] addr, logic [31:0] data, bit cp = 0, bit p = 0);
        op_t o;
        o.wr = wr; o.addr = addr; o.data = data; o.chk_pin = cp; o.pin = p;
        return o;
    endfunction

    initial begin
        logic [31:0] rv;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
        ext_in = '1;

        // reset read-back
        tbl.push_back(mk(0, 5'h00, 32'h0));
        tbl.push_back(mk(0, 5'h04, 32'hFFFF_FFFF));
        tbl.push_back(mk(0, 5'h08, 32'hFFFF_FFFF));
        tbl.push_back(mk(0, 5'h0C, 32'h0));
        tbl.push_back(mk(0, 5'h10, 32'h0));
        tbl.push_back(mk(0, 5'h14, 32'h0, 1, 0));
        // direction
        tbl.push_back(mk(1, 5'h04, 32'hAAAA_5555));
        tbl.push_back(mk(1, 5'h00, 32'hFFFF_0000));
        tbl.push_back(mk(0, 5'h04, 32'hAAAA_FFFF));
        tbl.push_back(mk(0, 5'h0C, 32'h0));
        // active-low level; a clear against a live level leaves it set
        tbl.push_back(mk(1, 5'h04, 32'hAAAA_5555));
        tbl.push_back(mk(1, 5'h00, 32'h0000_FFFF));
        tbl.push_back(mk(1, 5'h08, 32'h0));
        tbl.push_back(mk(0, 5'h0C, 32'h0000_AAAA, 1, 1));
        tbl.push_back(mk(1, 5'h0C, 32'h0));
        tbl.push_back(mk(0, 5'h0C, 32'h0000_AAAA, 1, 1));
        tbl.push_back(mk(1, 5'h08, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'h0C, 32'h0));
        tbl.push_back(mk(0, 5'h0C, 32'h0, 1, 0));
        // rising edge
        tbl.push_back(mk(1, 5'h00, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'h04, 32'h0));
        tbl.push_back(mk(1, 5'h10, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'h14, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'h08, 32'h0));
        tbl.push_back(mk(1, 5'h04, 32'h1234_5678));
        tbl.push_back(mk(0, 5'h0C, 32'h1234_5678, 1, 1));
        tbl.push_back(mk(1, 5'h08, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'h0C, 32'h0));
        tbl.push_back(mk(0, 5'h0C, 32'h0, 1, 0));
        tbl.push_back(mk(1, 5'h08, 32'h0));
        tbl.push_back(mk(1, 5'h04, 32'hEDCB_A987));
        tbl.push_back(mk(0, 5'h0C, 32'hEDCB_A987, 1, 1));
        // falling edge
        tbl.push_back(mk(1, 5'h08, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'h04, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 5'h14, 32'h0));
        tbl.push_back(mk(1, 5'h0C, 32'h0));
        tbl.push_back(mk(1, 5'h08, 32'h0));
        tbl.push_back(mk(1, 5'h04, 32'h1234_5678));
        tbl.push_back(mk(0, 5'h0C, 32'hEDCB_A987));
        tbl.push_back(mk(1, 5'h0C, 32'h0));
        tbl.push_back(mk(0, 5'h0C, 32'h0));
        tbl.push_back(mk(1, 5'h04, 32'hEDCB_A987));
        tbl.push_back(mk(0, 5'h0C, 32'h1234_5678, 1, 1));
        // unused offsets
        tbl.push_back(mk(1, 5'h18, 32'hDEAD_BEEF));
        tbl.push_back(mk(1, 5'h1C, 32'hCAFE_F00D));
        tbl.push_back(mk(0, 5'h18, 32'h0));
        tbl.push_back(mk(0, 5'h1C, 32'h0));

        idle(3);
        PRESETn = 1;
        chk_en = 1;
        idle(SS + 3);

        foreach (tbl[i]) begin
            if (tbl[i].wr) apb_write({27'd0, tbl[i].addr}, tbl[i].data);
            else begin
                apb_read({27'd0, tbl[i].addr}, rv);
                chk($sformatf("tbl[%0d] rd %h", i, tbl[i].addr), rv, tbl[i].data);
            end
            idle(SS + 3);
            if (tbl[i].chk_pin) chk($sformatf("tbl[%0d] irq pin", i), {31'd0, IRQ}, {31'd0, tbl[i].pin});
        end

        // reset in the access phase of an IRQ read, with status 0x12345678 pending
        @(negedge PCLK);
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 32'h0C;
        @(negedge PCLK);
        chk("midrst prdata before", bus.PRDATA, 32'h1234_5678);
        bus.PENABLE = 1;
        #2 PRESETn = 0;
        #1;
        chk("midrst prdata", bus.PRDATA, 32'h0);
        chk("midrst irq", {31'd0, IRQ}, 32'h0);
        chk("midrst gpio_o", GPIO_O, 32'h0);
        chk("midrst gpio_t", GPIO_T, 32'h0);
        @(negedge PCLK);
        bus.PSEL = 0; bus.PENABLE = 0;
        idle(2);
        #2 PRESETn = 1;
        idle(SS + 2);
        apb_read(32'h08, rv);
        chk("post-reset mask", rv, 32'hFFFF_FFFF);

        // random phase: the shadow model checks every cycle
        for (int it = 0; it < 600; it++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: apb_write({$urandom, 5'd0} | {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)}, $urandom);
                4, 5: begin
                    logic [31:0] a;
                    a = {$urandom, 5'd0} | {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
                    apb_read(a, rv);
                end
                6: begin @(negedge PCLK); ext_in = $urandom; end
                default: idle($urandom_range(0, 3));
            endcase
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
